bp_cce_branch_resolve: RTL and testbench

- Next-generation CCE branch unit.
- Evaluates microcode branch conditions with signed or unsigned compare, resolves mispredictions and computes the next PC for every instruction.
- Adds a PC-indexed branch history table (BHT) of 2-bit saturating counters. The fetch stage reads its taken prediction from the BHT; the execute stage trains it.
- Emits a registered redirect one cycle after a mispredicted branch executes.

---
 rtl/bp_cce_pkg.sv | 39 +++
 rtl/bp_cce_branch_resolve_if.sv | 45 ++++
 rtl/bp_cce_branch_bht.sv | 78 +++++++
 rtl/bp_cce_branch_resolve.sv | 116 +++++++++++
 tb/tb_bp_cce_branch_resolve.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bp_cce_pkg.sv
// Shared CCE branch-unit types: branch op codes, BHT counter states, init FSM
// states and the saturating counter update helper.
package bp_cce_pkg;

  typedef enum logic [2:0] {
    e_beq = 3'd0,
    e_bne = 3'd1,
    e_blt = 3'd2,
    e_ble = 3'd3
  } bp_cce_inst_branch_op_e;

  typedef enum logic [1:0] {
    e_bht_strong_nt = 2'b00,
    e_bht_weak_nt   = 2'b01,
    e_bht_weak_t    = 2'b10,
    e_bht_strong_t  = 2'b11
  } bp_cce_bht_ctr_e;

  typedef enum logic {
    e_init  = 1'b0,
    e_ready = 1'b1
  } bp_cce_branch_state_e;

  localparam bp_cce_bht_ctr_e bp_cce_bht_init_ctr_gp = e_bht_weak_nt;

  // Two-bit saturating counter step: up on taken, down on not-taken.
  function automatic bp_cce_bht_ctr_e bp_cce_bht_ctr_next(input bp_cce_bht_ctr_e ctr,
                                                          input logic            taken);
    bp_cce_bht_ctr_e nxt;
    nxt = ctr;
    if (taken && (ctr != e_bht_strong_t)) begin
      nxt = bp_cce_bht_ctr_e'(ctr + 2'b01);
    end else if (!taken && (ctr != e_bht_strong_nt)) begin
      nxt = bp_cce_bht_ctr_e'(ctr - 2'b01);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_cce_branch_resolve_if.sv
// Fetch/execute bundle of the CCE branch unit, including the BHT init FSM
// state as a debug observation point.
interface bp_cce_branch_resolve_if #(
  parameter int width_p        = 16,
  parameter int cce_pc_width_p = 8
) ();
  import bp_cce_pkg::*;

  // Handshake: an execute instruction is consumed on every clock edge where
  // exe_v_i and ready_o are both high; there is no back-pressure beyond ready_o.
  logic                       ready_o;
  logic [cce_pc_width_p-1:0]  fetch_pc_i;
  logic                       predict_taken_o;
  logic                       exe_v_i;
  logic                       exe_branch_i;
  logic                       exe_predicted_taken_i;
  bp_cce_inst_branch_op_e     exe_branch_op_i;
  logic                       exe_signed_i;
  logic [width_p-1:0]         opd_a_i;
  logic [width_p-1:0]         opd_b_i;
  logic [cce_pc_width_p-1:0]  exe_pc_i;
  logic [cce_pc_width_p-1:0]  exe_branch_target_i;
  logic                       mispredict_o;
  logic [cce_pc_width_p-1:0]  pc_o;
  logic                       redirect_v_o;
  logic [cce_pc_width_p-1:0]  redirect_pc_o;
  logic [31:0]                branch_count_o;
  logic [31:0]                mispredict_count_o;
  bp_cce_branch_state_e       bht_state_o;

  modport master (
    input  ready_o, predict_taken_o, mispredict_o, pc_o, redirect_v_o, redirect_pc_o,
           branch_count_o, mispredict_count_o, bht_state_o,
    output fetch_pc_i, exe_v_i, exe_branch_i, exe_predicted_taken_i, exe_branch_op_i,
           exe_signed_i, opd_a_i, opd_b_i, exe_pc_i, exe_branch_target_i
  );

  modport slave (
    output ready_o, predict_taken_o, mispredict_o, pc_o, redirect_v_o, redirect_pc_o,
           branch_count_o, mispredict_count_o, bht_state_o,
    input  fetch_pc_i, exe_v_i, exe_branch_i, exe_predicted_taken_i, exe_branch_op_i,
           exe_signed_i, opd_a_i, opd_b_i, exe_pc_i, exe_branch_target_i
  );

endinterface

// File: rtl/bp_cce_branch_bht.sv
// PC-indexed table of 2-bit saturating counters with a walk-through init FSM,
// one combinational read port (fetch) and one training port (execute).
module bp_cce_branch_bht
  import bp_cce_pkg::*;
#(
  parameter int bht_entries_p  = 16,
  parameter int cce_pc_width_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       ready_o,
  output bp_cce_branch_state_e       state_o,
  input  logic [cce_pc_width_p-1:0]  rd_pc_i,
  output logic                       rd_taken_o,
  input  logic                       wr_v_i,
  input  logic [cce_pc_width_p-1:0]  wr_pc_i,
  input  logic                       wr_taken_i
);

  localparam int idx_width_lp = $clog2(bht_entries_p);
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(bht_entries_p - 1);

  bp_cce_branch_state_e      state_q, state_d;
  logic [idx_width_lp-1:0]   idx_q, idx_d;
  bp_cce_bht_ctr_e           ctr_q [bht_entries_p];
  bp_cce_bht_ctr_e           ctr_d [bht_entries_p];
  logic [idx_width_lp-1:0]   rd_idx, wr_idx;
  logic                      unused_pc_bits;

  assign rd_idx = rd_pc_i[idx_width_lp-1:0];
  assign wr_idx = wr_pc_i[idx_width_lp-1:0];
  // Upper PC bits do not take part in indexing.
  assign unused_pc_bits = ^{rd_pc_i, wr_pc_i};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ctr_d   = ctr_q;
    case (state_q)
      e_init: begin
        ctr_d[idx_q] = bp_cce_bht_init_ctr_gp;
        idx_d        = idx_q + idx_width_lp'(1);
        if (idx_q == last_idx_lp) begin
          state_d = e_ready;
        end
      end
      e_ready: begin
        if (wr_v_i) begin
          ctr_d[wr_idx] = bp_cce_bht_ctr_next(ctr_q[wr_idx], wr_taken_i);
        end
      end
      default: begin
        state_d = e_init;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_init;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Counter contents need no reset: the init walk writes every entry before use.
  always_ff @(posedge clk_i) begin
    ctr_q <= ctr_d;
  end

  assign ready_o    = (state_q == e_ready);
  assign state_o    = state_q;
  assign rd_taken_o = ready_o & ctr_q[rd_idx][1];

endmodule

// File: rtl/bp_cce_branch_resolve.sv
// CCE branch unit: condition compare, mispredict/next-PC resolution, BHT
// training and a registered redirect. Define BP_CCE_BRANCH_STATS_EN for counters.
module bp_cce_branch_resolve
  import bp_cce_pkg::*;
#(
  parameter int width_p        = 16,
  parameter int cce_pc_width_p = 8,
  parameter int bht_entries_p  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  bp_cce_branch_resolve_if.slave   io
);

  logic                       ready;
  logic                       res;
  logic                       taken;
  logic                       mispredict;
  logic                       train_v;
  logic [cce_pc_width_p-1:0]  pc_plus1;
  logic [cce_pc_width_p-1:0]  pc_next;
  logic                       redirect_v_q, redirect_v_d;
  logic [cce_pc_width_p-1:0]  redirect_pc_q, redirect_pc_d;

  bp_cce_branch_bht #(
    .bht_entries_p  (bht_entries_p),
    .cce_pc_width_p (cce_pc_width_p)
  ) bht (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .ready_o    (ready),
    .state_o    (io.bht_state_o),
    .rd_pc_i    (io.fetch_pc_i),
    .rd_taken_o (io.predict_taken_o),
    .wr_v_i     (train_v),
    .wr_pc_i    (io.exe_pc_i),
    .wr_taken_i (taken)
  );

  always_comb begin
    res = 1'b0;
    case (io.exe_branch_op_i)
      e_beq: res = (io.opd_a_i == io.opd_b_i);
      e_bne: res = (io.opd_a_i != io.opd_b_i);
      e_blt: res = io.exe_signed_i ? ($signed(io.opd_a_i) <  $signed(io.opd_b_i))
                                   : (io.opd_a_i <  io.opd_b_i);
      e_ble: res = io.exe_signed_i ? ($signed(io.opd_a_i) <= $signed(io.opd_b_i))
                                   : (io.opd_a_i <= io.opd_b_i);
      default: res = 1'b0;
    endcase
  end

  // A non-branch has an implicit not-taken prediction, so it can never mispredict.
  assign taken      = io.exe_v_i & io.exe_branch_i & res;
  assign mispredict = io.exe_v_i & (taken != (io.exe_branch_i & io.exe_predicted_taken_i));
  assign pc_plus1   = io.exe_pc_i + cce_pc_width_p'(1);
  assign pc_next    = taken ? io.exe_branch_target_i : pc_plus1;
  assign train_v    = io.exe_v_i & io.exe_branch_i;

  always_comb begin
    redirect_v_d  = ready & mispredict;
    redirect_pc_d = redirect_pc_q;
    if (mispredict) begin
      redirect_pc_d = pc_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      redirect_v_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_v_q  <= redirect_v_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

`ifdef BP_CCE_BRANCH_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ready && train_v && (branch_count_q != 32'hFFFF_FFFF)) begin
      branch_count_d = branch_count_q + 32'd1;
    end
    if (ready && mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign io.branch_count_o     = branch_count_q;
  assign io.mispredict_count_o = mispredict_count_q;
`else
  assign io.branch_count_o     = '0;
  assign io.mispredict_count_o = '0;
`endif

  assign io.ready_o       = ready;
  assign io.mispredict_o  = mispredict;
  assign io.pc_o          = pc_next;
  assign io.redirect_v_o  = redirect_v_q;
  assign io.redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_bp_cce_branch_resolve.sv
// Self-checking bench for bp_cce_branch_resolve: vector table for compare/PC
// logic, scoreboarded redirects, and hand sequences for BHT/init corner cases.
module tb_bp_cce_branch_resolve;
  import bp_cce_pkg::*;

  logic clk;
  logic rst;

  bp_cce_branch_resolve_if #(.width_p(16), .cce_pc_width_p(8)) bus ();

  bp_cce_branch_resolve #(
    .width_p        (16),
    .cce_pc_width_p (8),
    .bht_entries_p  (16)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .io      (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard state
  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];
  logic       exp_ready;
  logic [7:0] model_rpc;

  typedef struct {
    logic                   v;
    logic                   branch;
    bp_cce_inst_branch_op_e op;
    logic                   sgn;
    logic [15:0]            a;
    logic [15:0]            b;
    logic                   pred;
    logic [7:0]             pc;
    logic [7:0]             tgt;
    logic                   exp_misp;
    logic [7:0]             exp_pc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_exe(input logic v, input logic branch, input bp_cce_inst_branch_op_e op,
                           input logic sgn, input logic [15:0] a, input logic [15:0] b,
                           input logic pred, input logic [7:0] pc, input logic [7:0] tgt);
    bus.exe_v_i               = v;
    bus.exe_branch_i          = branch;
    bus.exe_branch_op_i       = op;
    bus.exe_signed_i          = sgn;
    bus.opd_a_i               = a;
    bus.opd_b_i               = b;
    bus.exe_predicted_taken_i = pred;
    bus.exe_pc_i              = pc;
    bus.exe_branch_target_i   = tgt;
  endtask

  // Checks combinational outputs, pushes the expected redirect, clocks once, pops.
  task automatic check_cycle(input string name, input logic exp_misp, input logic [7:0] exp_pc);
    logic [8:0] e;
    #1;
    chk({name, "_mispredict"}, 32'(bus.mispredict_o), 32'(exp_misp));
    chk({name, "_pc"}, 32'(bus.pc_o), 32'(exp_pc));
    if (exp_misp) model_rpc = exp_pc;
    exp_q.push_back({exp_ready & exp_misp, model_rpc});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_redirect: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_redirect_v"}, 32'(bus.redirect_v_o), 32'(e[8]));
      chk({name, "_redirect_pc"}, 32'(bus.redirect_pc_o), 32'(e[7:0]));
    end
    bus.exe_v_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.exe_v_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_redirect_v", 32'(bus.redirect_v_o), 32'd0);
    chk("rst_redirect_pc", 32'(bus.redirect_pc_o), 32'd0);
    chk("rst_branch_count", bus.branch_count_o, 32'd0);
    chk("rst_mispredict_count", bus.mispredict_count_o, 32'd0);
    chk("rst_state", 32'(bus.bht_state_o), 32'(e_init));
    rst = 1'b0;
    model_rpc = 8'h00;
    exp_ready = 1'b0;
  endtask

  task automatic wait_ready(input int start);
    int cycles;
    cycles = start;
    while (!bus.ready_o && cycles < 64) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("ready_latency", 32'(cycles), 32'd16);
    chk("ready_state", 32'(bus.bht_state_o), 32'(e_ready));
    exp_ready = 1'b1;
  endtask

  initial begin
    int ones;
    rst       = 1'b1;
    exp_ready = 1'b0;
    model_rpc = 8'h00;
    bus.fetch_pc_i = 8'h00;
    drive_exe(1'b0, 1'b0, e_beq, 1'b0, 16'h0, 16'h0, 1'b0, 8'h00, 8'h00);

    // {v, branch, op, signed, a, b, pred, pc, target, exp mispredict, exp pc}
    vecs[0]  = '{1'b1, 1'b1, e_beq, 1'b0, 16'h0005, 16'h0005, 1'b1, 8'h10, 8'h40, 1'b0, 8'h40};
    vecs[1]  = '{1'b1, 1'b1, e_beq, 1'b0, 16'h0005, 16'h0006, 1'b0, 8'h11, 8'h40, 1'b0, 8'h12};
    vecs[2]  = '{1'b1, 1'b1, e_bne, 1'b0, 16'h0005, 16'h0006, 1'b0, 8'h12, 8'h50, 1'b1, 8'h50};
    vecs[3]  = '{1'b1, 1'b1, e_bne, 1'b0, 16'h0007, 16'h0007, 1'b1, 8'h13, 8'h50, 1'b1, 8'h14};
    vecs[4]  = '{1'b1, 1'b1, e_blt, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 8'h20, 8'h80, 1'b0, 8'h80};
    vecs[5]  = '{1'b1, 1'b1, e_blt, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 8'h20, 8'h80, 1'b1, 8'h21};
    vecs[6]  = '{1'b1, 1'b1, e_ble, 1'b1, 16'h8000, 16'h8000, 1'b0, 8'h30, 8'h90, 1'b1, 8'h90};
    vecs[7]  = '{1'b1, 1'b1, e_ble, 1'b0, 16'h0002, 16'h0001, 1'b0, 8'h31, 8'h90, 1'b0, 8'h32};
    vecs[8]  = '{1'b1, 1'b1, e_ble, 1'b1, 16'h7FFF, 16'h8000, 1'b0, 8'h32, 8'h91, 1'b0, 8'h33};
    vecs[9]  = '{1'b1, 1'b1, e_ble, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 8'h33, 8'h91, 1'b0, 8'h91};
    vecs[10] = '{1'b1, 1'b0, e_beq, 1'b0, 16'h0001, 16'h0001, 1'b1, 8'hFF, 8'h44, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b1, bp_cce_inst_branch_op_e'(3'd5), 1'b0, 16'h0001, 16'h0001, 1'b1,
                 8'h40, 8'h55, 1'b1, 8'h41};
    vecs[12] = '{1'b1, 1'b1, e_blt, 1'b1, 16'h0001, 16'hFFFF, 1'b0, 8'hFE, 8'h00, 1'b0, 8'hFF};
    vecs[13] = '{1'b0, 1'b1, e_beq, 1'b0, 16'h0003, 16'h0003, 1'b1, 8'h05, 8'h66, 1'b0, 8'h06};

    // reset, init latency, all-PC prediction sweep
    do_reset();
    wait_ready(0);
    ones = 0;
    for (int p = 0; p < 256; p++) begin
      bus.fetch_pc_i = 8'(p);
      #1;
      if (bus.predict_taken_o !== 1'b0) ones++;
    end
    chk("init_predict_sweep", 32'(ones), 32'd0);

    // mispredicted beq trains entry 0 to weak taken
    @(posedge clk);
    #1;
    bus.fetch_pc_i = 8'h20;
    drive_exe(1'b1, 1'b1, e_beq, 1'b0, 16'd5, 16'd5, 1'b0, 8'h10, 8'h40);
    check_cycle("beq_misp", 1'b1, 8'h40);
    chk("beq_trained_predict", 32'(bus.predict_taken_o), 32'd1);

    // saturation on index 3 observed via alias PC 0x13
    bus.fetch_pc_i = 8'h13;
    for (int i = 0; i < 4; i++) begin
      drive_exe(1'b1, 1'b1, e_beq, 1'b0, 16'd1, 16'd1, 1'b1, 8'h03, 8'h33);
      check_cycle("sat_taken", 1'b0, 8'h33);
      chk("sat_taken_predict", 32'(bus.predict_taken_o), 32'd1);
    end
    drive_exe(1'b1, 1'b1, e_beq, 1'b0, 16'd1, 16'd2, 1'b1, 8'h03, 8'h33);
    check_cycle("sat_nt1", 1'b1, 8'h04);
    chk("sat_nt1_predict", 32'(bus.predict_taken_o), 32'd1);
    drive_exe(1'b1, 1'b1, e_beq, 1'b0, 16'd1, 16'd2, 1'b1, 8'h03, 8'h33);
    check_cycle("sat_nt2", 1'b1, 8'h04);
    chk("sat_nt2_predict", 32'(bus.predict_taken_o), 32'd0);

    // same-cycle read and train: read sees the pre-update counter
    drive_exe(1'b1, 1'b1, e_beq, 1'b0, 16'd1, 16'd1, 1'b0, 8'h03, 8'h33);
    #1;
    chk("rbw_before", 32'(bus.predict_taken_o), 32'd0);
    check_cycle("rbw", 1'b1, 8'h33);
    chk("rbw_after", 32'(bus.predict_taken_o), 32'd1);

    // vector table
    for (int i = 0; i < 14; i++) begin
      drive_exe(vecs[i].v, vecs[i].branch, vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
                vecs[i].pred, vecs[i].pc, vecs[i].tgt);
      check_cycle($sformatf("vec%0d", i), vecs[i].exp_misp, vecs[i].exp_pc);
    end

    // reset pulse during init restarts the full sequence
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("midinit_ready", 32'(bus.ready_o), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rpc = 8'h00;
    exp_ready = 1'b0;
    drive_exe(1'b1, 1'b1, e_beq, 1'b0, 16'd1, 16'd2, 1'b1, 8'h07, 8'h70);
    check_cycle("init_exe", 1'b1, 8'h08);
    wait_ready(1);

    // stats: three branches, one mispredict, plus an uncounted non-branch
    drive_exe(1'b1, 1'b1, e_beq, 1'b0, 16'd1, 16'd1, 1'b1, 8'h50, 8'h60);
    check_cycle("st_b0", 1'b0, 8'h60);
    drive_exe(1'b1, 1'b0, e_beq, 1'b0, 16'd1, 16'd1, 1'b0, 8'h58, 8'h60);
    check_cycle("st_nb", 1'b0, 8'h59);
    drive_exe(1'b1, 1'b1, e_beq, 1'b0, 16'd1, 16'd2, 1'b0, 8'h51, 8'h60);
    check_cycle("st_b1", 1'b0, 8'h52);
    drive_exe(1'b1, 1'b1, e_bne, 1'b0, 16'd1, 16'd2, 1'b0, 8'h52, 8'h70);
    check_cycle("st_b2", 1'b1, 8'h70);
`ifdef BP_CCE_BRANCH_STATS_EN
    chk("branch_count", bus.branch_count_o, 32'd3);
    chk("mispredict_count", bus.mispredict_count_o, 32'd1);
`else
    chk("branch_count", bus.branch_count_o, 32'd0);
    chk("mispredict_count", bus.mispredict_count_o, 32'd0);
`endif

    // final report
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
